// File: rtl/if_id_buf.sv
// IF->ID instruction queue: DEPTH-entry circular buffer of (pc, inst) with valid/ready on both sides.
// Optional macro IF_ID_BYPASS_EN adds a same-cycle IF->ID path when the queue is empty.
module if_id_buf #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic q_valid;
  logic bypass;
  logic bypass_take;
  logic push;
  logic pop;

  assign q_valid  = (count_q != '0);
  // A same-cycle pop never frees a slot: if_ready looks only at registered occupancy.
  assign if_ready = (count_q < CNT_W'(DEPTH));
  assign count    = count_q;

`ifdef IF_ID_BYPASS_EN
  assign bypass      = !q_valid && if_valid && rdy && !flush;
  assign bypass_take = bypass && id_ready;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = if_valid && if_ready && rdy && !flush && !bypass_take;
  assign pop  = q_valid && id_ready && rdy && !flush;

  always_comb begin
    id_valid = q_valid || bypass;
    id_pc    = '0;
    id_inst  = '0;
    if (q_valid) begin
      id_pc   = pc_mem_q[head_q];
      id_inst = inst_mem_q[head_q];
    end else if (bypass) begin
      id_pc   = if_pc;
      id_inst = if_inst;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy) begin
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[tail_q]   <= if_pc;
      inst_mem_q[tail_q] <= if_inst;
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Bench for if_id_buf: directed stimulus pushes expected (pc, inst) into a queue; a monitor pops on each ID handshake.
module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b0;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] s_pc   [3] = '{32'h0, 32'h4, 32'h8};
  logic [31:0] s_inst [3] = '{32'h00000013, 32'h00100093, 32'h00200113};

  if_id_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_ready (id_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input bit expect_out);
    exp_t e;
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    if (expect_out) begin
      e.pc   = pc;
      e.inst = inst;
      expq.push_back(e);
    end
  endtask

  // Monitor: every ID-side handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rdy && !flush && id_valid && id_ready) begin
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL id_unexpected: got pc %0h with no entry expected", id_pc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("id_pc", {32'h0, id_pc}, {32'h0, e.pc});
        check("id_inst", {32'h0, id_inst}, {32'h0, e.inst});
      end
    end
  end

  initial begin
    // Reset held for two cycles.
    tick(); tick();
    mid();
    check("rst_count", {61'h0, count}, 64'd0);
    check("rst_id_valid", {63'h0, id_valid}, 64'd0);
    check("rst_id_pc", {32'h0, id_pc}, 64'd0);
    check("rst_id_inst", {32'h0, id_inst}, 64'd0);
    check("rst_if_ready", {63'h0, if_ready}, 64'd1);
    tick();
    rst = 1'b0;

    // Stream-through with ID always ready.
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(s_pc[i], s_inst[i], 1'b1);
      mid();
      check("stream_count_le1", {63'h0, (count <= 3'd1)}, 64'd1);
    end
    tick();
    if_valid = 1'b0;
    mid();
    check("stream_count_le1", {63'h0, (count <= 3'd1)}, 64'd1);
    repeat (2) tick();
    mid();
    check("stream_drained", {61'h0, count}, 64'd0);

    // Fill while ID stalls; fifth entry must be held off.
    tick();
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + 32'(4 * i), mk_inst(32'h100 + 32'(4 * i)), 1'b1);
      tick();
    end
    drive(32'h110, mk_inst(32'h110), 1'b1);
    mid();
    check("full_count", {61'h0, count}, 64'd4);
    check("full_if_ready", {63'h0, if_ready}, 64'd0);
    check("full_head_pc", {32'h0, id_pc}, 64'h100);
    tick();
    mid();
    check("full_hold_count", {61'h0, count}, 64'd4);
    tick();
    id_ready = 1'b1;
    mid();
    tick();
    mid();
    check("full_pop_only_count", {61'h0, count}, 64'd3);
    tick();
    if_valid = 1'b0;
    repeat (5) tick();
    mid();
    check("fill_drained", {61'h0, count}, 64'd0);

    // Flush discards queued entries and the same-cycle push.
    tick();
    id_ready = 1'b0;
    drive(32'h180, mk_inst(32'h180), 1'b0);
    tick();
    drive(32'h184, mk_inst(32'h184), 1'b0);
    tick();
    drive(32'h188, mk_inst(32'h188), 1'b0);
    tick();
    drive(32'h18C, mk_inst(32'h18C), 1'b0);
    flush    = 1'b1;
    id_ready = 1'b1;
    mid();
    check("preflush_count", {61'h0, count}, 64'd3);
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    mid();
    check("flush_count", {61'h0, count}, 64'd0);
    check("flush_id_valid", {63'h0, id_valid}, 64'd0);
    check("flush_if_ready", {63'h0, if_ready}, 64'd1);
    check("flush_id_pc", {32'h0, id_pc}, 64'd0);
    tick();
    drive(32'h200, mk_inst(32'h200), 1'b1);
    id_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    repeat (3) tick();
    mid();
    check("postflush_count", {61'h0, count}, 64'd0);
    check("postflush_expq", 64'(expq.size()), 64'd0);

    // rdy freeze with push, pop and flush all requested.
    tick();
    id_ready = 1'b0;
    drive(32'h400, mk_inst(32'h400), 1'b1);
    tick();
    drive(32'h404, mk_inst(32'h404), 1'b1);
    tick();
    drive(32'h408, mk_inst(32'h408), 1'b0);
    rdy      = 1'b0;
    flush    = 1'b1;
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("freeze_count", {61'h0, count}, 64'd2);
      check("freeze_id_pc", {32'h0, id_pc}, 64'h400);
      check("freeze_id_inst", {32'h0, id_inst}, {32'h0, mk_inst(32'h400)});
      if (k < 2) tick();
    end
    tick();
    rdy      = 1'b1;
    flush    = 1'b0;
    if_valid = 1'b0;
    repeat (3) tick();
    mid();
    check("unfreeze_count", {61'h0, count}, 64'd0);

`ifdef IF_ID_BYPASS_EN
    tick();
    drive(32'h300, mk_inst(32'h300), 1'b1);
    id_ready = 1'b1;
    mid();
    check("bypass_id_valid", {63'h0, id_valid}, 64'd1);
    check("bypass_id_pc", {32'h0, id_pc}, 64'h300);
    tick();
    if_valid = 1'b0;
    mid();
    check("bypass_count", {61'h0, count}, 64'd0);
`endif

    // Bounded drain before the final scoreboard check.
    id_ready = 1'b1;
    for (int w = 0; w < 20 && expq.size() != 0; w++) tick();
    mid();
    check("final_expq_empty", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Parametrised IF→ID pipeline stage replacing the plain single-entry IF/ID register.
- Small circular instruction queue of DEPTH entries (pc, inst) between fetch and decode.
- valid/ready handshake on both sides, synchronous flush for branch redirect, and a global `rdy` freeze.
- Lets IF keep fetching while ID stalls, and ID keep decoding while memory is busy.

Parameters:
- ADDR_W, 32, width of pc fields.
- INST_W, 32, width of instruction fields.
- DEPTH, 4, number of queue entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; 0 freezes all state.
- flush  in  1  discard all queued entries (branch mispredict / jump redirect).
- if_valid  in  1  IF presents a fetched instruction.
- if_pc  in  ADDR_W  pc of fetched instruction.
- if_inst  in  INST_W  fetched instruction word.
- if_ready  out  1  queue can accept an entry this cycle.
- id_valid  out  1  head entry available to ID.
- id_pc  out  ADDR_W  head pc.
- id_inst  out  INST_W  head instruction.
- id_ready  in  1  ID consumes head this cycle.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge. rst has priority over rdy, flush, push and pop.
- Reset: head ptr = 0, tail ptr = 0, count = 0, so id_valid = 0, id_pc = 0, id_inst = 0, if_ready = 1. Storage contents are don't-care.
- Reset mid-operation: queue empties on that edge; entries in flight are lost; no output glitch beyond combinational settling.
- Push = if_valid & if_ready & rdy & !flush; writes tail entry, tail+1 (mod DEPTH).
- Pop = id_valid & id_ready & rdy & !flush; head+1 (mod DEPTH).
- count next = count + push − pop. Push and pop in the same cycle leave count unchanged.
- if_ready = (count < DEPTH). Depends only on registered state; a same-cycle pop does not free a slot, so full with a simultaneous pop still rejects push.
- id_valid = (count != 0). id_pc/id_inst = head entry when valid, else 0 (never stale data).
- Latency: entry pushed at edge N is visible on id_* after edge N, one cycle; FIFO order is preserved.
- Flush: on the edge with flush=1 (and rdy=1), head = tail = 0 and count = 0; push and pop that cycle are discarded. The next cycle, id_valid = 0 and if_ready = 1.
- rdy = 0: pointers, count and storage hold; flush, push and pop are ignored; outputs stay at their registered values.
- Pointer wrap-around: natural modulo DEPTH; full/empty are distinguished by count, not by pointer equality.
- No other state machine; the occupancy counter is the only control state.

Optional Feature:
- Macro IF_ID_BYPASS_EN.
- Defined: when count == 0 and if_valid = 1 (no flush), id_valid = 1 and id_pc/id_inst = if_pc/if_inst combinationally in the same cycle. If id_ready = 1 too, the entry is consumed directly and not written (count stays 0). Otherwise it is pushed normally. if_ready is unchanged.
- Undefined: no IF→ID combinational path; minimum latency is 1 cycle as above.

Test Plan:
- Reset/idle: assert rst 2 cycles → count = 0, id_valid = 0, id_pc = 0, id_inst = 0, if_ready = 1.
- Stream through, id_ready = 1: push pc 0x0, 0x4, 0x8 with insts 0x00000013, 0x00100093, 0x00200113 on consecutive cycles → same order on id_* each delayed 1 cycle; count never exceeds 1.
- Fill and stall: id_ready = 0, push 5 entries (pc 0x100..0x110) → first 4 accepted, count = 4, if_ready = 0, 5th held by IF. Release id_ready → 0x100, 0x104, 0x108, 0x10C, then 0x110 drain in order.
- Full + simultaneous pop: count = 4, if_valid = 1, id_ready = 1 → pop only, count = 3, push not taken that cycle.
- Flush: count = 3, assert flush with if_valid = 1 and id_ready = 1 → next cycle count = 0, id_valid = 0, the pushed entry is absent; a following push of pc 0x200 appears alone.
- rdy freeze: count = 2, rdy = 0 for 3 cycles with push, pop and flush asserted → count, id_pc and id_inst unchanged. With IF_ID_BYPASS_EN, empty + push pc 0x300 + id_ready = 1 → id_pc = 0x300 the same cycle, count stays 0.
